// File: rtl/drive_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : drive_sequencer
// Description : Line-sensor debounce, drive-mode FSM and per-channel duty
//               soft-start ramp for a two-channel PWM motor drive.
// Revision    : 1.0 - initial release
// ============================================================================
module drive_sequencer #(
    parameter int RAMP_DIV = 4,
    parameter int DUTY_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              period_tick,
    input  logic              enable,
    input  logic              sens_l,
    input  logic              sens_r,
    input  logic [DUTY_W-1:0] duty_max,
    output logic [DUTY_W-1:0] l_duty,
    output logic [DUTY_W-1:0] r_duty,
    output logic [2:0]        state,
    output logic              at_target
);

    localparam int c_RDIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [c_RDIV_W-1:0] c_RDIV_LAST = c_RDIV_W'(RAMP_DIV - 1);

    typedef enum logic [2:0] {
        c_IDLE  = 3'd0,
        c_FWD   = 3'd1,
        c_LEFT  = 3'd2,
        c_RIGHT = 3'd3,
        c_HALT  = 3'd4,
        c_DRAIN = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    state_t              w_mode;
    logic [1:0]          r_pend;
    logic [1:0]          r_committed;
    logic [1:0]          w_sample;
    logic [c_RDIV_W-1:0] r_rdiv;
    logic                w_step;
    logic [DUTY_W-1:0]   r_l_duty;
    logic [DUTY_W-1:0]   r_r_duty;
    logic [DUTY_W-1:0]   w_l_tgt;
    logic [DUTY_W-1:0]   w_r_tgt;

    // One-LSB move toward the target; a duty at target holds.
    function automatic logic [DUTY_W-1:0] f_step(input logic [DUTY_W-1:0] cur,
                                                 input logic [DUTY_W-1:0] tgt);
        if (cur < tgt)
            return cur + 1'b1;
        else if (cur > tgt)
            return cur - 1'b1;
        else
            return cur;
    endfunction

    assign w_sample = {sens_l, sens_r};

    // A pattern commits only after two consecutive identical tick samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend      <= 2'b00;
            r_committed <= 2'b00;
        end else if (period_tick) begin
            r_pend <= w_sample;
            if ((w_sample == r_pend) && (r_pend != r_committed))
                r_committed <= r_pend;
        end
    end

    always_comb begin
        w_mode = c_FWD;
        case (r_committed)
            2'b00:   w_mode = c_FWD;
            2'b10:   w_mode = c_LEFT;
            2'b01:   w_mode = c_RIGHT;
            default: w_mode = c_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= c_IDLE;
        else if (period_tick)
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (enable)
                    w_state_nxt = w_mode;
            end
            c_DRAIN: begin
                if (enable)
                    w_state_nxt = w_mode;
                else if ((r_l_duty == '0) && (r_r_duty == '0))
                    w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = enable ? w_mode : c_DRAIN;
            end
        endcase
    end

    always_comb begin
        w_l_tgt = '0;
        w_r_tgt = '0;
        case (r_state)
            c_FWD: begin
                w_l_tgt = duty_max;
                w_r_tgt = duty_max;
            end
            c_LEFT:  w_r_tgt = duty_max;
            c_RIGHT: w_l_tgt = duty_max;
            default: begin
                w_l_tgt = '0;
                w_r_tgt = '0;
            end
        endcase
    end

    assign w_step = (r_rdiv == c_RDIV_LAST);

    // Duties step using targets of the pre-edge state, so a mode change on
    // a step tick still moves toward the old targets.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdiv   <= '0;
            r_l_duty <= '0;
            r_r_duty <= '0;
        end else if (period_tick) begin
            r_rdiv <= w_step ? '0 : r_rdiv + 1'b1;
            if (w_step) begin
                r_l_duty <= f_step(r_l_duty, w_l_tgt);
                r_r_duty <= f_step(r_r_duty, w_r_tgt);
            end
        end
    end

    assign l_duty    = r_l_duty;
    assign r_duty    = r_r_duty;
    assign state     = r_state;
    assign at_target = (r_l_duty == w_l_tgt) && (r_r_duty == w_r_tgt);

endmodule
`default_nettype wire

// File: tb/tb_drive_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_drive_sequencer
// Description : Scoreboard bench for drive_sequencer with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_drive_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       period_tick = 1'b0;
    logic       enable = 1'b0;
    logic       sens_l = 1'b0;
    logic       sens_r = 1'b0;
    logic [2:0] duty_max = 3'd0;
    logic [2:0] l_duty;
    logic [2:0] r_duty;
    logic [2:0] state;
    logic       at_target;

    int n_tests = 0;
    int n_fail  = 0;
    int tcount  = 0;

    typedef struct {
        logic       chk;
        logic [2:0] l;
        logic [2:0] r;
        logic [2:0] st;
        logic       at;
        string      nm;
    } exp_t;

    exp_t sb[$];

    drive_sequencer #(.RAMP_DIV(4), .DUTY_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .period_tick(period_tick),
        .enable     (enable),
        .sens_l     (sens_l),
        .sens_r     (sens_r),
        .duty_max   (duty_max),
        .l_duty     (l_duty),
        .r_duty     (r_duty),
        .state      (state),
        .at_target  (at_target)
    );

    always #5 clk = ~clk;

    // Monitor: each tick edge presents a new output set; compare on the
    // following falling edge against the oldest scoreboard entry.
    initial begin : mon
        exp_t e;
        forever begin
            @(posedge clk);
            if (period_tick && rst) begin
                @(negedge clk);
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_empty: output with no expected entry (l=%0d r=%0d state=%0d)",
                             l_duty, r_duty, state);
                end else begin
                    e = sb.pop_front();
                    if (e.chk) begin
                        n_tests++;
                        if (l_duty !== e.l || r_duty !== e.r || state !== e.st || at_target !== e.at) begin
                            n_fail++;
                            $display("FAIL %s: got l=%0d r=%0d state=%0d at=%0d, expected l=%0d r=%0d state=%0d at=%0d",
                                     e.nm, l_duty, r_duty, state, at_target, e.l, e.r, e.st, e.at);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit, tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    // Issue one period tick and queue its expected outcome.
    task automatic tick(input logic chk, input logic [2:0] l, input logic [2:0] r,
                        input logic [2:0] st, input logic at, input string nm);
        exp_t e;
        e.chk = chk; e.l = l; e.r = r; e.st = st; e.at = at; e.nm = nm;
        sb.push_back(e);
        period_tick = 1'b1;
        @(negedge clk); #1;
        period_tick = 1'b0;
        @(negedge clk); #1;
        tcount++;
    endtask

    task automatic skip_to(input int t);
        while (tcount < t)
            tick(1'b0, 3'd0, 3'd0, 3'd0, 1'b0, "");
    endtask

    task automatic chk_at(input int t, input logic [2:0] l, input logic [2:0] r,
                          input logic [2:0] st, input logic at, input string nm);
        skip_to(t - 1);
        tick(1'b1, l, r, st, at, nm);
    endtask

    task automatic direct(input logic [2:0] l, input logic [2:0] r,
                          input logic [2:0] st, input logic at, input string nm);
        n_tests++;
        if (l_duty !== l || r_duty !== r || state !== st || at_target !== at) begin
            n_fail++;
            $display("FAIL %s: got l=%0d r=%0d state=%0d at=%0d, expected l=%0d r=%0d state=%0d at=%0d",
                     nm, l_duty, r_duty, state, at_target, l, r, st, at);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        direct(3'd0, 3'd0, 3'd0, 1'b1, "reset_state");
        rst = 1'b1;
        @(negedge clk); #1;
        tcount   = 0;
        enable   = 1'b1;
        duty_max = 3'd5;

        // Soft start in FWD
        chk_at(1,  3'd0, 3'd0, 3'd1, 1'b0, "fwd_entry");
        chk_at(4,  3'd1, 3'd1, 3'd1, 1'b0, "first_step");
        chk_at(8,  3'd2, 3'd2, 3'd1, 1'b0, "second_step");
        chk_at(20, 3'd5, 3'd5, 3'd1, 1'b1, "cruise");
        chk_at(24, 3'd5, 3'd5, 3'd1, 1'b1, "cruise_hold");

        // Left turn after debounce
        sens_l = 1'b1;
        chk_at(25, 3'd5, 3'd5, 3'd1, 1'b1, "left_pend");
        chk_at(26, 3'd5, 3'd5, 3'd1, 1'b1, "left_commit");
        chk_at(27, 3'd5, 3'd5, 3'd2, 1'b0, "left_state");
        chk_at(28, 3'd4, 3'd5, 3'd2, 1'b0, "left_step1");
        chk_at(40, 3'd1, 3'd5, 3'd2, 1'b0, "left_step4");
        chk_at(44, 3'd0, 3'd5, 3'd2, 1'b1, "left_done");

        // Back to FWD, ramp left channel up again
        sens_l = 1'b0;
        chk_at(47, 3'd0, 3'd5, 3'd1, 1'b0, "back_fwd");
        chk_at(64, 3'd5, 3'd5, 3'd1, 1'b1, "refwd_done");

        // One-tick glitch must not commit
        sens_l = 1'b1;
        chk_at(65, 3'd5, 3'd5, 3'd1, 1'b1, "glitch_a");
        sens_l = 1'b0;
        chk_at(66, 3'd5, 3'd5, 3'd1, 1'b1, "glitch_b");
        chk_at(67, 3'd5, 3'd5, 3'd1, 1'b1, "glitch_c");
        chk_at(68, 3'd5, 3'd5, 3'd1, 1'b1, "glitch_d");

        // Retarget downward mid-cruise
        duty_max = 3'd2;
        chk_at(69, 3'd5, 3'd5, 3'd1, 1'b0, "retarget");
        chk_at(72, 3'd4, 3'd4, 3'd1, 1'b0, "retarget_4");
        chk_at(76, 3'd3, 3'd3, 3'd1, 1'b0, "retarget_3");
        chk_at(80, 3'd2, 3'd2, 3'd1, 1'b1, "retarget_done");

        // Ramp back up, drop enable exactly on a step tick
        duty_max = 3'd5;
        skip_to(91);
        enable = 1'b0;
        chk_at(92,  3'd5, 3'd5, 3'd5, 1'b0, "drain_step_tick");
        chk_at(96,  3'd4, 3'd4, 3'd5, 1'b0, "drain_4");
        chk_at(112, 3'd0, 3'd0, 3'd5, 1'b1, "drain_zero");
        chk_at(113, 3'd0, 3'd0, 3'd0, 1'b1, "idle_after_drain");

        // Re-enable during DRAIN leaves immediately
        enable = 1'b1;
        chk_at(114, 3'd0, 3'd0, 3'd1, 1'b0, "reenable_idle");
        skip_to(120);
        enable = 1'b0;
        chk_at(121, 3'd2, 3'd2, 3'd5, 1'b0, "drain_again");
        enable = 1'b1;
        chk_at(122, 3'd2, 3'd2, 3'd1, 1'b0, "drain_exit");

        // Asynchronous reset between clock edges
        #3;
        rst = 1'b0;
        #1;
        direct(3'd0, 3'd0, 3'd0, 1'b1, "async_reset");
        @(negedge clk); #1;
        rst    = 1'b1;
        tcount = 0;
        chk_at(1, 3'd0, 3'd0, 3'd1, 1'b0, "post_rst_fwd");
        chk_at(3, 3'd0, 3'd0, 3'd1, 1'b0, "post_rst_nostep");
        chk_at(4, 3'd1, 3'd1, 3'd1, 1'b0, "post_rst_step");

        // No ticks: everything holds, including the ramp divider
        repeat (20) @(negedge clk);
        #1;
        direct(3'd1, 3'd1, 3'd1, 1'b0, "tick_hold");
        chk_at(7, 3'd1, 3'd1, 3'd1, 1'b0, "hold_nostep");
        chk_at(8, 3'd2, 3'd2, 3'd1, 1'b0, "hold_step");

        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/drive_sequencer.md
# drive_sequencer

Steering and soft-start sequencer for the two-channel PWM motor drive. It debounces the left/right line-sensor pair and selects a drive mode. Each mode maps to per-channel target duties, and the block ramps each channel's 3-bit duty command one step at a time toward its target. It sits between the sensor inputs and the two PWM generators, which consume `l_duty`/`r_duty`. All updates are synchronised to the PWM period boundary, so a duty never changes mid-period.

## Interface
- `RAMP_DIV`, default 4: PWM periods per one-LSB ramp step (≥1).
- `DUTY_W`, default 3: duty command width.

Ports:
- `clk`  in  1  system clock (same clock as the PWM counter).
- `rst`  in  1  asynchronous, active-low reset.
- `period_tick`  in  1  one-cycle pulse at each PWM period start (trigger counter == 0).
- `enable`  in  1  drive enable, level.
- `sens_l`, `sens_r`  in  1 each  raw line sensors.
- `duty_max`  in  DUTY_W  cruise duty target.
- `l_duty`, `r_duty`  out  DUTY_W  registered duty commands to the PWM channels.
- `state`  out  3  current mode: IDLE=0, FWD=1, LEFT=2, RIGHT=3, HALT=4, DRAIN=5.
- `at_target`  out  1  1 when both duties equal their targets.

## Operation
- Registers advance only on `clk` edges where `period_tick`=1; the one exception is reset.
- All decisions use pre-edge register values.

Debounce:
- `pend` ← {`sens_l`,`sens_r`} on every tick.
- `committed` ← `pend` when the new sample equals `pend` and differs from `committed`.
- Result: a sensor pattern needs 2 consecutive tick samples before it commits.

Mode FSM, evaluated per tick:
- `enable`=0 in any state except IDLE → DRAIN.
- DRAIN → IDLE when `l_duty`=`r_duty`=0 (pre-edge).
- IDLE with `enable`=1 → mode(`committed`).
- FWD/LEFT/RIGHT/HALT with `enable`=1 → mode(`committed`).
- mode(00)=FWD, mode(10)=LEFT, mode(01)=RIGHT, mode(11)=HALT.

Targets (combinational from the registered state and live `duty_max`):
- FWD: L=`duty_max`, R=`duty_max`.
- LEFT: L=0, R=`duty_max`.
- RIGHT: L=`duty_max`, R=0.
- HALT, DRAIN, IDLE: L=0, R=0.

Ramp:
- `rdiv` counts ticks 0..RAMP_DIV-1 and wraps.
- On a tick with `rdiv`=RAMP_DIV-1, each duty moves ±1 toward its pre-edge target. A duty already equal to its target holds.
- There is no overflow or underflow: duties stay within 0..2^DUTY_W-1 because targets are in range.
- A `duty_max` change mid-ramp simply retargets the ramp; a duty above the new target ramps down.
- `at_target` is combinational from the registered duties and current targets.

## Timing
- Reset (async, `rst`=0): `l_duty`=`r_duty`=0, `state`=IDLE, `rdiv`=0, `pend`=`committed`=00.
- The asserted reset clears all outputs immediately, including mid-ramp or mid-DRAIN, with no clock needed.
- Reset release requires no special sequencing.
- A sensor change becomes `committed` at the 2nd tick of stable sampling. `state` reflects it at the 3rd tick.
- Duty outputs change on the `clk` edge of a step tick and are stable for the entire following PWM period.
- RAMP_DIV=1 steps every tick.
- A state change and a ramp step on the same tick: the step uses the old state's targets.
- `enable` dropping on a step tick: state → DRAIN, and the step still moves toward the old targets.
- `enable` reasserted during DRAIN: the next tick leaves DRAIN for mode(`committed`) without waiting for zero duty.
- `period_tick` held 0: everything holds indefinitely, including `rdiv`.

## Test plan
- Reset, then `enable`=1, sensors 00, `duty_max`=5, RAMP_DIV=4:
  - `state`=FWD after tick 1.
  - Both duties are 1 after tick 4 and 5 after tick 20.
  - `at_target`=1 from then on, and duties hold.
- In FWD at duty 5, sensors → 10 held:
  - `committed`=10 after tick 2 and `state`=LEFT after tick 3.
  - `l_duty` decrements by 1 every 4 ticks to 0; `r_duty` stays 5.
- Sensor glitch 10 for one tick, then back to 00: `committed` and `state` unchanged, duties unchanged.
- `enable`→0 at duty 5:
  - `state`=DRAIN on the next tick; duties ramp to 0.
  - `state`=IDLE on the first tick after both reach 0.
  - Re-enable during DRAIN returns to FWD on the next tick.
- `duty_max` 5→2 in FWD at duty 5: both duties step down 5→4→3→2 at 4-tick intervals, then `at_target`=1.
- Assert `rst`=0 mid-ramp between clock edges: duties=0 and `state`=IDLE immediately. After release, the ramp restarts from 0 with `rdiv`=0.
